// File: rtl/r2r_wave_pkg.sv
// Shared constants for the R2R ladder waveform front-end.
// Mode encodings and default parameter values used by the top and its bench.
package r2r_wave_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_DIRECT = 2'd0;
    localparam mode_t MODE_SAW    = 2'd1;
    localparam mode_t MODE_TRI    = 2'd2;
    localparam mode_t MODE_PLAY   = 2'd3;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 16;
    localparam int DIV_W_DEF = 8;

endpackage

// File: rtl/r2r_wave_gen_buf.sv
// Playback sample storage: one synchronous write port, one asynchronous read port.
// Pointers and fill level are owned by the parent.
module r2r_sample_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/r2r_wave_gen.sv
// Registered sample source for the R2R ladder DAC: direct, sawtooth, triangle
// or buffered playback at a programmable divided sample rate.
module r2r_wave_gen
    import r2r_wave_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             clr,
    output logic [WIDTH-1:0] dac,
    output logic             tick,
    output logic             wrap
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [WIDTH-1:0] DAC_MAX = '1;

    logic [1:0]       r_mode_q;
    logic [DIV_W-1:0] r_cnt;
    logic             r_dir_down;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_len;
    logic [WIDTH-1:0] r_dac;
    logic             r_tick;
    logic             r_wrap;

    logic             w_wr_ready;
    logic             w_we;
    logic             w_mode_chg;
    logic             w_tick_now;
    logic             w_last;
    logic             w_play_adv;
    logic [WIDTH-1:0] w_rdata;

    assign w_wr_ready = r_len < LW'(DEPTH);
    assign w_we       = wr_valid && w_wr_ready && !clr;
    assign w_mode_chg = mode != r_mode_q;
    assign w_tick_now = !w_mode_chg && ena && (r_cnt >= div);
    // Guarded compare keeps the read pointer in range even if len shrank under it.
    assign w_last     = (r_len != '0) && ({1'b0, r_rd_ptr} >= (r_len - LW'(1)));
    assign w_play_adv = w_tick_now && (r_mode_q == MODE_PLAY) && (r_len != '0) && !clr;

    r2r_sample_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (din),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode_q   <= MODE_DIRECT;
            r_cnt      <= '0;
            r_dir_down <= 1'b0;
            r_dac      <= '0;
            r_tick     <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            if (w_mode_chg) begin
                r_mode_q   <= mode;
                r_cnt      <= '0;
                r_dir_down <= 1'b0;
                r_dac      <= '0;
            end else if (ena) begin
                if (w_tick_now) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                    case (r_mode_q)
                        MODE_DIRECT: r_dac <= din;
                        MODE_SAW: begin
                            r_dac  <= r_dac + 1'b1;
                            r_wrap <= (r_dac == DAC_MAX);
                        end
                        MODE_TRI: begin
                            if (r_dir_down) begin
                                r_dac <= r_dac - 1'b1;
                                if (r_dac == WIDTH'(1)) begin
                                    r_dir_down <= 1'b0;
                                    r_wrap     <= 1'b1;
                                end
                            end else begin
                                r_dac <= r_dac + 1'b1;
                                if (r_dac == DAC_MAX - 1'b1) begin
                                    r_dir_down <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            if (clr || r_len == '0) begin
                                r_dac <= '0;
                            end else begin
                                r_dac  <= w_rdata;
                                r_wrap <= w_last;
                            end
                        end
                    endcase
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_len    <= '0;
        end else begin
            if (clr || w_mode_chg) begin
                r_rd_ptr <= '0;
            end else if (w_play_adv) begin
                r_rd_ptr <= w_last ? '0 : r_rd_ptr + 1'b1;
            end
            if (clr) begin
                r_wr_ptr <= '0;
                r_len    <= '0;
            end else if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_len    <= r_len + 1'b1;
            end
        end
    end

    assign wr_ready = w_wr_ready;
    assign dac      = r_dac;
    assign tick     = r_tick;
    assign wrap     = r_wrap;

endmodule
